// File: rtl/spi_slave_pkg.sv
// Shared constants for the SPI target: register map, status bits,
// FSM encoding and version word.
package spi_slave_pkg;

  localparam logic [1:0] SPI_SLV_TX      = 2'd0;
  localparam logic [1:0] SPI_SLV_RX      = 2'd1;
  localparam logic [1:0] SPI_SLV_STATUS  = 2'd2;
  localparam logic [1:0] SPI_SLV_VERSION = 2'd3;

  localparam int ST_RX_VALID = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_OVERRUN  = 2;
  localparam int ST_ABORT    = 3;
  localparam int ST_BUSY     = 4;

  // ASCII "SPS1"
  localparam logic [31:0] SPI_VERSION_STR = 32'h5350_5331;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/spi_slave_sync.sv
// Two-flop synchroniser plus delay flop for edge detection
// of one asynchronous SPI line.
module spi_slave_sync (
  input  logic clk,
  input  logic rst_int,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic dly;

  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      meta <= 1'b0;
      sync <= 1'b0;
      dly  <= 1'b0;
    end else begin
      meta <= din;
      sync <= meta;
      dly  <= sync;
    end
  end

  assign dout = sync;
  assign rise = sync & ~dly;
  assign fall = ~sync & dly;

endmodule

// File: rtl/spi_slave.sv
// SPI target, 32-bit LSB-first frames, fully oversampled in clk.
// CPU register bus: TX / RX / STATUS / VERSION.
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst_int,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  input  logic [ADDR_W-1:0] address,
  input  logic              sel,
  input  logic              read,
  input  logic              write,
  input  logic              sclk,
  input  logic              ss,
  input  logic              mosi,
  output logic              miso,
  output logic              irq
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  logic sclk_s, sclk_rise, sclk_fall;
  logic ss_s, ss_rise, ss_fall;
  logic mosi_s, mosi_rise, mosi_fall;

  spi_slave_sync u_sclk (
    .clk     (clk),
    .rst_int (rst_int),
    .din     (sclk),
    .dout    (sclk_s),
    .rise    (sclk_rise),
    .fall    (sclk_fall)
  );

  spi_slave_sync u_ss (
    .clk     (clk),
    .rst_int (rst_int),
    .din     (ss),
    .dout    (ss_s),
    .rise    (ss_rise),
    .fall    (ss_fall)
  );

  spi_slave_sync u_mosi (
    .clk     (clk),
    .rst_int (rst_int),
    .din     (mosi),
    .dout    (mosi_s),
    .rise    (mosi_rise),
    .fall    (mosi_fall)
  );

  logic unused_sync;
  assign unused_sync = &{1'b0, sclk_s, ss_s,
                         mosi_rise, mosi_fall};

  state_t            state;
  state_t            state_nx;
  logic [DATA_W-1:0] tx_buf;
  logic [DATA_W-1:0] shift_tx;
  logic [DATA_W-1:0] shift_rx;
  logic [DATA_W-1:0] rx_data;
  logic [DATA_W-1:0] rx_next;
  logic [DATA_W-1:0] status;
  logic [CNT_W-1:0]  bit_cnt;
  logic              tx_empty;
  logic              rx_valid;
  logic              overrun;
  logic              abort;

  logic rd_rx, rd_st, wr_tx;
  logic frame_start, frame_done, frame_abort;
  logic shifting;

  assign rd_rx = sel & read
               & (address == ADDR_W'(SPI_SLV_RX));
  assign rd_st = sel & read
               & (address == ADDR_W'(SPI_SLV_STATUS));
  assign wr_tx = sel & write
               & (address == ADDR_W'(SPI_SLV_TX));

  assign shifting    = (state == SHIFT) & ~ss_rise;
  assign frame_start = (state == IDLE) & ss_fall;
  assign frame_abort = (state == SHIFT) & ss_rise;
  assign frame_done  = shifting & sclk_rise
                     & (bit_cnt == CNT_W'(DATA_W - 1));
  assign rx_next     = {mosi_s, shift_rx[DATA_W-1:1]};

  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (ss_fall) state_nx = SHIFT;
      SHIFT: begin
        if (ss_rise)         state_nx = IDLE;
        else if (frame_done) state_nx = DONE;
      end
      DONE:    if (ss_rise) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      shift_tx <= '0;
      shift_rx <= '0;
      bit_cnt  <= '0;
    end else if (frame_start) begin
      shift_tx <= tx_empty ? '0 : tx_buf;
      bit_cnt  <= '0;
    end else if (shifting) begin
      if (sclk_rise) begin
        shift_rx <= rx_next;
        bit_cnt  <= bit_cnt + CNT_W'(1);
      end
      if (sclk_fall) shift_tx <= shift_tx >> 1;
    end
  end

  // A TX write coinciding with frame load keeps the new word pending.
  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      tx_buf   <= '0;
      tx_empty <= 1'b1;
    end else if (wr_tx) begin
      tx_buf   <= data_in;
      tx_empty <= 1'b0;
    end else if (frame_start) begin
      tx_empty <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
      abort    <= 1'b0;
    end else begin
      if (frame_done) rx_data <= rx_next;
      if (frame_done) rx_valid <= 1'b1;
      else if (rd_rx) rx_valid <= 1'b0;
      if (frame_done & rx_valid & ~rd_rx)
        overrun <= 1'b1;
      else if (rd_st)
        overrun <= 1'b0;
      if (frame_abort) abort <= 1'b1;
      else if (rd_st)  abort <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      miso <= 1'b0;
      irq  <= 1'b0;
    end else begin
      miso <= (state == SHIFT) & shift_tx[0];
      irq  <= rx_valid | overrun;
    end
  end

  always_comb begin
    status = '0;
    status[ST_RX_VALID] = rx_valid;
    status[ST_TX_EMPTY] = tx_empty;
    status[ST_OVERRUN]  = overrun;
    status[ST_ABORT]    = abort;
    status[ST_BUSY]     = (state != IDLE);
  end

  always_comb begin
    data_out = '0;
    if (sel & read) begin
      unique case (1'b1)
        address == ADDR_W'(SPI_SLV_RX):
          data_out = rx_data;
        address == ADDR_W'(SPI_SLV_STATUS):
          data_out = status;
        address == ADDR_W'(SPI_SLV_VERSION):
          data_out = DATA_W'(SPI_VERSION_STR);
        default:
          data_out = '0;
      endcase
    end
  end

endmodule
